// File: rtl/logical_cmp_pkg.sv
// rtl/logical_cmp_pkg.sv - shared types and the single-bit compare rule for serial_logical_cmp
package logical_cmp_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} cmp_state_t;
  typedef enum logic [1:0] {CMP_EQ, CMP_LT, CMP_GT} cmp_result_t;

  // invert flips the sense for a two's-complement sign bit, where a 1 is the smaller value
  function automatic cmp_result_t cmp_bit(input logic a_bit, input logic b_bit,
                                          input logic invert);
    if (a_bit == b_bit) return CMP_EQ;
    return (a_bit ^ invert) ? CMP_GT : CMP_LT;
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// rtl/cmp_bit_cell.sv - combinational one-bit magnitude compare with sign-bit inversion
module cmp_bit_cell
  import logical_cmp_pkg::*;
(
  input  logic        a_bit,
  input  logic        b_bit,
  input  logic        invert,
  output cmp_result_t res
);

  assign res = cmp_bit(a_bit, b_bit, invert);

endmodule

// File: rtl/serial_logical_cmp.sv
// rtl/serial_logical_cmp.sv - bit-serial MSB-first comparator reporting eq/lt/gt with a done pulse
// SERIAL_LOGICAL_CMP_EARLY_EXIT_EN finishes on the first differing bit instead of after N bits.
module serial_logical_cmp
  import logical_cmp_pkg::*;
#(
  parameter int N      = 8,
  parameter int SIGNED = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         eq,
  output logic         lt,
  output logic         gt
);

  localparam int            CW      = $clog2(N);
  localparam logic [CW-1:0] CNT_MSB = CW'(N - 1);
`ifdef SERIAL_LOGICAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  cmp_state_t    state;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  logic [CW-1:0] cnt;
  logic          decided;
  cmp_result_t   res;

  cmp_result_t   bit_res;
  cmp_result_t   res_next;
  logic          invert;
  logic          hit;
  logic          last;

  assign invert = (SIGNED != 0) && (cnt == CNT_MSB);

  cmp_bit_cell u_cell (
    .a_bit  (sa[N-1]),
    .b_bit  (sb[N-1]),
    .invert (invert),
    .res    (bit_res)
  );

  // only the first mismatch from the MSB counts; later ones leave res untouched
  assign hit      = !decided && (bit_res != CMP_EQ);
  assign res_next = hit ? bit_res : res;
  assign last     = (cnt == '0) || (EARLY_EXIT && hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      res     <= CMP_EQ;
      busy    <= 1'b0;
      done    <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
      gt      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa      <= a;
            sb      <= b;
            cnt     <= CNT_MSB;
            decided <= 1'b0;
            res     <= CMP_EQ;
            eq      <= 1'b0;
            lt      <= 1'b0;
            gt      <= 1'b0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          sa  <= {sa[N-2:0], 1'b0};
          sb  <= {sb[N-2:0], 1'b0};
          cnt <= cnt - CW'(1);
          if (hit) begin
            decided <= 1'b1;
            res     <= bit_res;
          end
          if (last) begin
            done  <= 1'b1;
            eq    <= (res_next == CMP_EQ);
            lt    <= (res_next == CMP_LT);
            gt    <= (res_next == CMP_GT);
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_logical_cmp.sv
// tb/tb_serial_logical_cmp.sv - scoreboard bench for serial_logical_cmp, unsigned and signed instances
module tb_serial_logical_cmp;

  localparam int N = 8;
`ifdef SERIAL_LOGICAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    bit sgn;
    bit eq;
    bit lt;
    bit gt;
    int lat;
    int t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic u_start = 1'b0, s_start = 1'b0;
  logic [N-1:0] u_a = '0, u_b = '0, s_a = '0, s_b = '0;
  logic u_busy, u_done, u_eq, u_lt, u_gt;
  logic s_busy, s_done, s_eq, s_lt, s_gt;

  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  serial_logical_cmp #(.N(N), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .start(u_start), .a(u_a), .b(u_b),
    .busy(u_busy), .done(u_done), .eq(u_eq), .lt(u_lt), .gt(u_gt)
  );

  serial_logical_cmp #(.N(N), .SIGNED(1)) s_dut (
    .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b),
    .busy(s_busy), .done(s_done), .eq(s_eq), .lt(s_lt), .gt(s_gt)
  );

  function automatic exp_t model(input bit sgn, input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    bit found;
    e.sgn = sgn;
    e.eq  = (x == y);
    e.lt  = sgn ? ($signed(x) < $signed(y)) : (x < y);
    e.gt  = sgn ? ($signed(x) > $signed(y)) : (x > y);
    e.lat = N + 1;
    e.t0  = 0;
    found = 1'b0;
    if (EARLY) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (!found && x[i] != y[i]) begin
          found = 1'b1;
          e.lat = (N - i) + 1;
        end
      end
    end
    return e;
  endfunction

  function automatic logic [3:0] outs(input bit sgn);
    return sgn ? {s_done, s_eq, s_lt, s_gt} : {u_done, u_eq, u_lt, u_gt};
  endfunction

  // leaves the caller #1 after the edge that sampled start
  task automatic start_cmp(input bit sgn, input logic [N-1:0] x, input logic [N-1:0] y);
    @(negedge clk);
    if (sgn) begin s_start = 1'b1; s_a = x; s_b = y; end
    else     begin u_start = 1'b1; u_a = x; u_b = y; end
    exp_q.push_back(model(sgn, x, y));
    @(posedge clk); #1;
    u_start = 1'b0;
    s_start = 1'b0;
  endtask

  task automatic wait_done(input bit sgn, output int lat);
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (outs(sgn)[3]) return;
    end
    vectors++; miscompares++;
    $display("FAIL done_timeout: no done within 40 cycles (sgn=%0d)", sgn);
    lat = -1;
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if ({u_busy, u_done, u_eq, u_lt, u_gt, s_busy, s_done, s_eq, s_lt, s_gt} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_state: got u=%b%b%b%b%b s=%b%b%b%b%b want all 0",
               u_busy, u_done, u_eq, u_lt, u_gt, s_busy, s_done, s_eq, s_lt, s_gt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors;
    bit          sg_t[10] = '{0, 1, 0, 1, 1, 0, 0, 1, 0, 1};
    logic [7:0]  a_t[10]  = '{8'h3C, 8'h3C, 8'h80, 8'h80, 8'hFF, 8'hFF, 8'h00, 8'h7F, 8'h01, 8'h00};
    logic [7:0]  b_t[10]  = '{8'h3C, 8'h3C, 8'h7F, 8'h01, 8'hFE, 8'hFE, 8'hFF, 8'h80, 8'h00, 8'h80};
    for (int v = 0; v < 16; v++) begin
      bit sg;
      logic [7:0] x, y;
      int lat;
      exp_t e;
      if (v < 10) begin sg = sg_t[v]; x = a_t[v]; y = b_t[v]; end
      else begin
        sg = v[0];
        x = 8'($urandom);
        y = (v == 12) ? x : 8'($urandom);
      end
      start_cmp(sg, x, y);
      vectors++;
      if ((sg ? s_busy : u_busy) !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_after_start: vec %0d got 0 want 1", v);
      end
      wait_done(sg, lat);
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL scoreboard_empty: vec %0d", v);
      end else begin
        e = exp_q.pop_front();
        vectors++;
        if (outs(sg)[2:0] !== {e.eq, e.lt, e.gt}) begin
          miscompares++;
          $display("FAIL result: vec %0d sgn=%0d a=%h b=%h got eq/lt/gt=%b want %b",
                   v, sg, x, y, outs(sg)[2:0], {e.eq, e.lt, e.gt});
        end
        vectors++;
        if (lat != e.lat) begin
          miscompares++;
          $display("FAIL latency: vec %0d a=%h b=%h got %0d want %0d", v, x, y, lat, e.lat);
        end
      end
      @(posedge clk); #1;
      vectors++;
      if ({outs(sg)[3], (sg ? s_busy : u_busy)} !== 2'b00) begin
        miscompares++;
        $display("FAIL done_pulse_width: vec %0d done/busy=%b want 00", v,
                 {outs(sg)[3], (sg ? s_busy : u_busy)});
      end
    end
  endtask

  task automatic test_start_ignored;
    int lat;
    exp_t e;
    logic [2:0] got;
    start_cmp(0, 8'h10, 8'h20);
    lat = 1;
    got = 3'b000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      u_start = 1'b1; u_a = 8'hFF; u_b = 8'h00;
      @(posedge clk); #1;
      lat++;
      if (u_done) begin
        got = {u_eq, u_lt, u_gt};
        break;
      end
    end
    // start stays high through the DONE cycle and must not be taken
    @(posedge clk); #1;
    u_start = 1'b0;
    e = exp_q.pop_front();
    vectors++;
    if (got !== {e.eq, e.lt, e.gt} || lat != e.lat) begin
      miscompares++;
      $display("FAIL start_ignored_result: got %b lat %0d want %b lat %0d",
               got, lat, {e.eq, e.lt, e.gt}, e.lat);
    end
    vectors++;
    if ({u_busy, u_eq, u_lt, u_gt} !== {1'b0, e.eq, e.lt, e.gt}) begin
      miscompares++;
      $display("FAIL start_in_done: busy/eq/lt/gt=%b want %b",
               {u_busy, u_eq, u_lt, u_gt}, {1'b0, e.eq, e.lt, e.gt});
    end
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    exp_t e;
    @(negedge clk);
    u_start = 1'b1; u_a = 8'h5A; u_b = 8'h5A;
    for (int idx = 1; idx <= 30; idx++) begin
      @(posedge clk); #1;
      if ((idx - 1) % (N + 2) == 0) begin
        e = model(0, 8'h5A, 8'h5A);
        e.t0 = idx;
        exp_q.push_back(e);
      end
      if (u_done) begin
        ndone++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_unexpected_done: at edge %0d", idx);
        end else begin
          e = exp_q.pop_front();
          if (idx != e.t0 + e.lat - 1 || u_eq !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_timing: done at edge %0d eq=%b want edge %0d eq=1",
                     idx, u_eq, e.t0 + e.lat - 1);
          end
        end
      end
    end
    u_start = 1'b0;
    vectors++;
    if (ndone != 3 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d dones want 3", ndone);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic test_hold;
    int lat;
    exp_t e;
    start_cmp(0, 8'h80, 8'h7F);
    wait_done(0, lat);
    e = exp_q.pop_front();
    vectors++;
    if ({u_eq, u_lt, u_gt} !== {e.eq, e.lt, e.gt}) begin
      miscompares++;
      $display("FAIL hold_result: got %b want %b", {u_eq, u_lt, u_gt}, {e.eq, e.lt, e.gt});
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({u_done, u_eq, u_lt, u_gt} !== {1'b0, e.eq, e.lt, e.gt}) begin
        miscompares++;
        $display("FAIL hold_stable: cycle %0d got %b want %b", i,
                 {u_done, u_eq, u_lt, u_gt}, {1'b0, e.eq, e.lt, e.gt});
      end
    end
    start_cmp(0, 8'h01, 8'h02);
    vectors++;
    if ({u_eq, u_lt, u_gt} !== 3'b000) begin
      miscompares++;
      $display("FAIL start_clears: got %b want 000", {u_eq, u_lt, u_gt});
    end
    wait_done(0, lat);
    e = exp_q.pop_front();
    vectors++;
    if ({u_eq, u_lt, u_gt} !== {e.eq, e.lt, e.gt}) begin
      miscompares++;
      $display("FAIL hold_next_result: got %b want %b", {u_eq, u_lt, u_gt}, {e.eq, e.lt, e.gt});
    end
  endtask

  task automatic test_abort;
    start_cmp(0, 8'hA5, 8'h5A);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({u_busy, u_done, u_eq, u_lt, u_gt} !== 5'b0) begin
      miscompares++;
      $display("FAIL abort_reset: busy/done/eq/lt/gt=%b want 00000",
               {u_busy, u_done, u_eq, u_lt, u_gt});
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({u_busy, u_done} !== 2'b00) begin
        miscompares++;
        $display("FAIL abort_no_done: cycle %0d busy/done=%b want 00", i, {u_busy, u_done});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_vectors;
    test_start_ignored;
    test_back_to_back;
    test_hold;
    test_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
